hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core.
- Sequences the IF/ID/EX/MEM pipeline registers around the execution stage: load-use stalls, branch/jump flushes from EX, and data-memory wait freezes.
- Generates the forwarding selects for both EX ALU operands.
- Keeps stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stalls, EX redirect
// flushes, data-memory wait freezes, operand forwarding selects and perf counters.
module hazard_ctrl #(
  parameter int REG_ADDR     = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic [REG_ADDR-1:0] i_id_rs1,
  input  logic [REG_ADDR-1:0] i_id_rs2,
  input  logic                i_id_rs1_used,
  input  logic                i_id_rs2_used,
  input  logic [REG_ADDR-1:0] i_ex_rs1,
  input  logic [REG_ADDR-1:0] i_ex_rs2,
  input  logic [REG_ADDR-1:0] i_ex_rd,
  input  logic                i_ex_reg_wr,
  input  logic                i_ex_mem_rd,
  input  logic                i_ex_flush,
  input  logic [REG_ADDR-1:0] i_mem_rd,
  input  logic                i_mem_reg_wr,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic                i_wb_reg_wr,
  input  logic                i_mem_busy,
  output logic                o_stall_if,
  output logic                o_stall_id,
  output logic                o_stall_ex,
  output logic                o_stall_mem,
  output logic                o_bubble_ex,
  output logic                o_flush_if_id,
  output logic                o_flush_id_ex,
  output logic [1:0]          o_fwd_a,
  output logic [1:0]          o_fwd_b,
  output logic [1:0]          o_state,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit               MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [REG_ADDR-1:0] REG_ZERO  = {REG_ADDR{1'b0}};

  state_e             state_r;
  logic [2:0]         fcnt_r;
  logic               pend_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [CNT_W-1:0]   flush_cnt_r;

  logic               load_use_s;
  logic               stall_all_s;
  logic               stall_front_s;
  logic               bubble_s;
  logic               flush_s;
  logic               issue_flush_s;
  logic               unused_s;

  // MEM result is younger than WB, so it wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR-1:0] src,
    input logic [REG_ADDR-1:0] mem_rd,
    input logic                mem_wr,
    input logic [REG_ADDR-1:0] wb_rd,
    input logic                wb_wr
  );
    logic [1:0] sel;
    if (mem_wr && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (wb_wr && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign o_fwd_a = fwd_sel(i_ex_rs1, i_mem_rd, i_mem_reg_wr, i_wb_rd, i_wb_reg_wr);
  assign o_fwd_b = fwd_sel(i_ex_rs2, i_mem_rd, i_mem_reg_wr, i_wb_rd, i_wb_reg_wr);

  // Loads always write rd, so the EX write-enable plays no part in hazard detection.
  assign unused_s = i_ex_reg_wr;

  assign load_use_s = i_ex_mem_rd && (i_ex_rd != REG_ZERO) &&
                      ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

  // Pipeline control decode; MEM_WAIT falls back to RUN rules in the cycle memory is ready.
  always_comb begin
    stall_all_s   = 1'b0;
    stall_front_s = 1'b0;
    bubble_s      = 1'b0;
    flush_s       = 1'b0;
    issue_flush_s = 1'b0;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (i_mem_busy) begin
          stall_all_s = 1'b1;
        end else if (i_ex_flush || pend_r) begin
          flush_s       = 1'b1;
          issue_flush_s = 1'b1;
        end else if (load_use_s) begin
          stall_front_s = 1'b1;
          bubble_s      = 1'b1;
        end else begin
          stall_all_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        flush_s       = 1'b1;
        stall_all_s   = i_mem_busy;
        issue_flush_s = i_ex_flush;
      end
      default: begin
        flush_s = 1'b0;
      end
    endcase
  end

  assign o_stall_if    = stall_all_s | stall_front_s;
  assign o_stall_id    = stall_all_s | stall_front_s;
  assign o_stall_ex    = stall_all_s;
  assign o_stall_mem   = stall_all_s;
  assign o_bubble_ex   = bubble_s;
  assign o_flush_if_id = flush_s;
  assign o_flush_id_ex = flush_s;
  assign o_state       = state_r;
  assign o_stall_cnt   = stall_cnt_r;
  assign o_flush_cnt   = flush_cnt_r;

  // Sequencer state, flush-length counter and deferred redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      fcnt_r  <= 3'd0;
      pend_r  <= 1'b0;
    end else if (clk_en) begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (i_mem_busy) begin
            state_r <= ST_MEM_WAIT;
            pend_r  <= pend_r | i_ex_flush;
          end else if (issue_flush_s) begin
            pend_r <= 1'b0;
            if (MULTI_FLUSH) begin
              state_r <= ST_FLUSH;
              fcnt_r  <= FLUSH_RELOAD;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (i_ex_flush) begin
            fcnt_r <= FLUSH_RELOAD;
          end else if (fcnt_r <= 3'd1) begin
            fcnt_r  <= 3'd0;
            state_r <= ST_RUN;
          end else begin
            fcnt_r <= fcnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          fcnt_r  <= 3'd0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (clk_en) begin
      if (o_stall_if && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (issue_flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (FLUSH_CYCLES 1/3/5) share stimulus
// and are compared every cycle against a behavioural model plus literal checkpoints.
module tb_hazard_ctrl;
  localparam int N = 3;
  localparam int FCS [N] = '{1, 3, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clk_en;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_reg_wr, ex_mem_rd, ex_flush;
  logic       mem_reg_wr, wb_reg_wr, mem_busy;

  logic        o_sif [N], o_sid [N], o_sex [N], o_smem [N], o_bub [N], o_fif [N], o_fid [N];
  logic [1:0]  o_fa [N], o_fb [N], o_st [N];
  logic [31:0] o_sc [N], o_fc [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_ctrl #(.REG_ADDR(5), .FLUSH_CYCLES(FCS[g]), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
      .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
      .i_ex_reg_wr(ex_reg_wr), .i_ex_mem_rd(ex_mem_rd), .i_ex_flush(ex_flush),
      .i_mem_rd(mem_rd), .i_mem_reg_wr(mem_reg_wr),
      .i_wb_rd(wb_rd), .i_wb_reg_wr(wb_reg_wr), .i_mem_busy(mem_busy),
      .o_stall_if(o_sif[g]), .o_stall_id(o_sid[g]), .o_stall_ex(o_sex[g]),
      .o_stall_mem(o_smem[g]), .o_bubble_ex(o_bub[g]),
      .o_flush_if_id(o_fif[g]), .o_flush_id_ex(o_fid[g]),
      .o_fwd_a(o_fa[g]), .o_fwd_b(o_fb[g]), .o_state(o_st[g]),
      .o_stall_cnt(o_sc[g]), .o_flush_cnt(o_fc[g])
    );
  end

  int nvec = 0;
  int nerr = 0;

  // Model: remaining forced-flush cycles, waiting flag, deferred redirect, counters.
  int     m_left [N] = '{0, 0, 0};
  bit     m_wait [N] = '{0, 0, 0};
  bit     m_pend [N] = '{0, 0, 0};
  longint m_sc   [N] = '{0, 0, 0};
  longint m_fc   [N] = '{0, 0, 0};

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d (FLUSH_CYCLES=%0d): got %0h want %0h", nm, k, FCS[k], act, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (mem_reg_wr && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
    if (wb_reg_wr && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    clk_en = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; ex_flush = 1'b0; mem_reg_wr = 1'b0;
    wb_reg_wr = 1'b0; mem_busy = 1'b0;
  endtask

  // One clock: compare all instances at negedge, advance the model, return at posedge+1.
  task automatic tick();
    bit lu, s_all, s_front, bub, fl;
    logic [1:0] est;
    @(negedge clk);
    lu = ex_mem_rd && ex_rd != 5'd0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        m_left[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end
      s_all = 0; s_front = 0; bub = 0; fl = 0;
      if (m_left[k] > 0) begin
        est = 2'b10; fl = 1; s_all = mem_busy;
      end else begin
        est = m_wait[k] ? 2'b01 : 2'b00;
        if (mem_busy) s_all = 1;
        else if (ex_flush || m_pend[k]) fl = 1;
        else if (lu) begin s_front = 1; bub = 1; end
      end
      chk("stall_if", k, o_sif[k], s_all | s_front);
      chk("stall_id", k, o_sid[k], s_all | s_front);
      chk("stall_ex", k, o_sex[k], s_all);
      chk("stall_mem", k, o_smem[k], s_all);
      chk("bubble_ex", k, o_bub[k], bub);
      chk("flush_if_id", k, o_fif[k], fl);
      chk("flush_id_ex", k, o_fid[k], fl);
      chk("fwd_a", k, o_fa[k], m_fwd(ex_rs1));
      chk("fwd_b", k, o_fb[k], m_fwd(ex_rs2));
      chk("state", k, o_st[k], est);
      chk("stall_cnt", k, o_sc[k], m_sc[k]);
      chk("flush_cnt", k, o_fc[k], m_fc[k]);
      if (rst_n && clk_en) begin
        if (s_all || s_front) m_sc[k] = (m_sc[k] == 64'hFFFF_FFFF) ? m_sc[k] : m_sc[k] + 1;
        if (m_left[k] > 0) begin
          if (ex_flush) begin m_fc[k]++; m_left[k] = FCS[k] - 1; end
          else m_left[k]--;
        end else if (mem_busy) begin
          m_wait[k] = 1; m_pend[k] = m_pend[k] | ex_flush;
        end else begin
          m_wait[k] = 0;
          if (ex_flush || m_pend[k]) begin m_pend[k] = 0; m_fc[k]++; m_left[k] = FCS[k] - 1; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct { logic [4:0] rs1, rs2, mrd; logic mwr; logic [4:0] wrd; logic wwr; } fwd_vec_t;
  fwd_vec_t fv [6] = '{
    '{5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1},
    '{5'd9, 5'd9, 5'd9, 1'b0, 5'd9, 1'b1},
    '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1},
    '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b1},
    '{5'd7, 5'd8, 5'd7, 1'b0, 5'd8, 1'b0},
    '{5'd12, 5'd12, 5'd13, 1'b1, 5'd12, 1'b1}
  };

  initial begin
    rst_n = 1'b0;
    clr();
    #1;
    chk("lit_rst_state", 0, o_st[0], 2'b00);
    chk("lit_rst_stall", 0, o_sif[0], 1'b0);
    chk("lit_rst_flush", 0, o_fif[0], 1'b0);
    chk("lit_rst_scnt", 2, o_sc[2], 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // forwarding priority
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_wr = 1'b1; wb_rd = 5'd3; wb_reg_wr = 1'b1;
    #1; chk("lit_fwd_mem", 0, o_fa[0], 2'b10);
    tick();
    mem_rd = 5'd4; ex_rs2 = 5'd4;
    #1; chk("lit_fwd_wb", 0, o_fa[0], 2'b01); chk("lit_fwdb_mem", 0, o_fb[0], 2'b10);
    tick();
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
    #1; chk("lit_fwd_x0", 0, o_fa[0], 2'b00);
    tick();

    // load-use: one-cycle stall plus bubble
    clr(); ex_mem_rd = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    #1; chk("lit_lu_stall", 0, o_sif[0], 1'b1); chk("lit_lu_bubble", 0, o_bub[0], 1'b1);
    chk("lit_lu_stall_ex", 0, o_sex[0], 1'b0);
    tick();
    clr();
    #1; chk("lit_lu_drop", 0, o_sif[0], 1'b0); chk("lit_lu_scnt", 0, o_sc[0], 32'd1);
    tick();
    ex_mem_rd = 1'b1; ex_rd = 5'd0; id_rs1_used = 1'b1; tick();
    ex_rd = 5'd6; id_rs1 = 5'd6; id_rs1_used = 1'b0; tick();
    id_rs1_used = 1'b1; ex_mem_rd = 1'b0; tick();

    // redirect overrides load-use
    clr(); ex_mem_rd = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1; ex_flush = 1'b1;
    #1; chk("lit_fl_flush", 0, o_fif[0], 1'b1); chk("lit_fl_bubble", 0, o_bub[0], 1'b0);
    chk("lit_fl_stall", 0, o_sif[0], 1'b0);
    tick();
    clr();
    #1; chk("lit_fl_cnt", 0, o_fc[0], 32'd1); chk("lit_fl1_done", 0, o_fif[0], 1'b0);
    chk("lit_fl3_c2", 1, o_fif[1], 1'b1); chk("lit_fl3_state", 1, o_st[1], 2'b10);
    tick();
    chk("lit_fl3_c3", 1, o_fif[1], 1'b1);
    tick();
    chk("lit_fl3_done", 1, o_fif[1], 1'b0); chk("lit_fl3_run", 1, o_st[1], 2'b00);
    idle(3);

    // memory wait with a redirect arriving mid-wait
    mem_busy = 1'b1;
    #1; chk("lit_mw_stall_mem", 0, o_smem[0], 1'b1); chk("lit_mw_st0", 0, o_st[0], 2'b00);
    tick();
    ex_flush = 1'b1;
    #1; chk("lit_mw_st1", 0, o_st[0], 2'b01); chk("lit_mw_noflush", 0, o_fif[0], 1'b0);
    tick();
    ex_flush = 1'b0; tick(); tick();
    mem_busy = 1'b0;
    #1; chk("lit_mw_pend_fl", 0, o_fif[0], 1'b1); chk("lit_mw_release", 0, o_sif[0], 1'b0);
    tick();
    clr();
    #1; chk("lit_mw_fcnt", 0, o_fc[0], 32'd2); chk("lit_mw_scnt", 0, o_sc[0], 32'd5);
    idle(5);

    // clock enable low freezes state and counters
    clk_en = 1'b0; mem_busy = 1'b1;
    #1; chk("lit_ce_stall", 0, o_sif[0], 1'b1);
    tick(); tick(); tick();
    chk("lit_ce_scnt", 0, o_sc[0], 32'd5); chk("lit_ce_state", 0, o_st[0], 2'b00);
    clk_en = 1'b1; tick();
    chk("lit_ce_resume", 0, o_sc[0], 32'd6);
    mem_busy = 1'b0; tick();
    clk_en = 1'b0; ex_flush = 1'b1;
    #1; chk("lit_ce_flush_comb", 0, o_fif[0], 1'b1);
    tick();
    clr();
    #1; chk("lit_ce_fcnt", 0, o_fc[0], 32'd2);
    tick();

    // redirect restarts an ongoing flush; memory wait during flush
    ex_flush = 1'b1; tick(); clr(); tick(); ex_flush = 1'b1; tick(); clr();
    #1; chk("lit_rs_c1", 1, o_fif[1], 1'b1);
    tick();
    chk("lit_rs_c2", 1, o_fif[1], 1'b1);
    tick();
    chk("lit_rs_end", 1, o_fif[1], 1'b0);
    idle(3);
    ex_flush = 1'b1; tick(); clr(); mem_busy = 1'b1; tick(); tick(); mem_busy = 1'b0; idle(6);
    mem_busy = 1'b1; tick(); mem_busy = 1'b0; ex_flush = 1'b1; tick(); idle(6);

    // asynchronous reset in the second flush cycle
    ex_flush = 1'b1; tick(); clr();
    #1; chk("lit_ar_inflush", 2, o_fif[2], 1'b1);
    #1; rst_n = 1'b0;
    #1; chk("lit_ar_state", 2, o_st[2], 2'b00); chk("lit_ar_flush", 2, o_fif[2], 1'b0);
    chk("lit_ar_scnt", 2, o_sc[2], 32'd0); chk("lit_ar_fcnt", 2, o_fc[2], 32'd0);
    tick();
    rst_n = 1'b1;
    mem_busy = 1'b1; tick(); ex_flush = 1'b1; tick(); clr();
    #1; chk("lit_arw_pend", 0, o_fif[0], 1'b1);
    rst_n = 1'b0;
    #1; chk("lit_arw_flush", 0, o_fif[0], 1'b0); chk("lit_arw_state", 0, o_st[0], 2'b00);
    tick();
    rst_n = 1'b1; tick(); tick();

    // assorted forwarding patterns
    for (int i = 0; i < 6; i++) begin
      ex_rs1 = fv[i].rs1; ex_rs2 = fv[i].rs2; mem_rd = fv[i].mrd; mem_reg_wr = fv[i].mwr;
      wb_rd = fv[i].wrd; wb_reg_wr = fv[i].wwr;
      tick();
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
